// File: rtl/sample_tx_pkg.sv
// Shared definitions for the sample/strobe producer: FSM state encoding and default widths.
// Optional feature macro used by this slice: DONE_TIMEOUT_EN.
package sample_tx_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_FIFO_AW = 2;
    localparam int DEF_RATE_W  = 8;
    localparam int DEF_TO_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_STROBE    = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_WAIT_RATE = 2'b11
    } tx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with an occupancy count; full/empty come straight from the
// registered count, and pushes into a full FIFO or pops from an empty one are ignored.
module sample_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o      = (count_q == FULL_COUNT);
    assign empty_o     = (count_q == '0);
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_data_o = mem_q[rd_ptr_q];

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sample_strobe_tx.sv
// Producer end of the sample/strobe link into the moving-average filter.
// Define DONE_TIMEOUT_EN to abandon a sample when the filter never answers with done_i.
module sample_strobe_tx
    import sample_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FIFO_AW = DEF_FIFO_AW,
    parameter int RATE_W  = DEF_RATE_W
`ifdef DONE_TIMEOUT_EN
    ,
    parameter int TO_W    = DEF_TO_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate_div,
    output logic [DATA_W-1:0] data_o,
    output logic              strobe_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic              timeout_o
);

    tx_state_e         state_q;
    logic [DATA_W-1:0] data_q;
    logic [RATE_W-1:0] gap_q;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign pop = (state_q == ST_IDLE) && enable && !fifo_empty;

    sample_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (wr_valid),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef DONE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;
`endif

    // data_q is written only when a sample leaves the FIFO, so it stays put while
    // the filter works on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            gap_q     <= '0;
`ifdef DONE_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        data_q  <= head_data;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
`ifdef DONE_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_i) begin
                        if (rate_div == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_q   <= rate_div;
                            state_q <= ST_WAIT_RATE;
                        end
                    end
`ifdef DONE_TIMEOUT_EN
                    else if (to_cnt_q == '1) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_WAIT_RATE: begin
                    if (gap_q <= RATE_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_ready = !fifo_full;
    assign data_o   = data_q;
    assign strobe_o = (state_q == ST_STROBE);
    assign busy_o   = (state_q != ST_IDLE);

`ifdef DONE_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sample_strobe_tx.sv
// Directed self-checking bench for sample_strobe_tx; the timeout scenario runs only
// when DONE_TIMEOUT_EN is defined.
module tb_sample_strobe_tx;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       enable;
    logic [7:0] rate_div;
    logic [7:0] data_o;
    logic       strobe_o;
    logic       done_i;
    logic       busy_o;
    logic       timeout_o;

    int totalChecks = 0;
    int badChecks   = 0;

    sample_strobe_tx dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .enable    (enable),
        .rate_div  (rate_div),
        .data_o    (data_o),
        .strobe_o  (strobe_o),
        .done_i    (done_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // One clock: inputs are held across the edge, outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic done);
        wr_data  = data;
        wr_valid = valid;
        done_i   = done;
        tick();
        wr_valid = 1'b0;
        done_i   = 1'b0;
    endtask

    task automatic waitStrobe(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (strobe_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic countStrobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (strobe_o) n++;
        end
    endtask

    logic       seen;
    logic       stable;
    int         n;
    logic [7:0] expData [4];

    initial begin
        expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h33; expData[3] = 8'h44;
        reset = 1'b1; wr_data = '0; wr_valid = 1'b0; enable = 1'b0; rate_div = '0; done_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_data", data_o, 8'h00);
        checkOutput("rst_strobe", strobe_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_timeout", timeout_o, 0);
        checkOutput("rst_wr_ready", wr_ready, 1);

        $display("[TB] single sample latency");
        enable = 1'b1;
        applyStimulus(8'h10, 1'b1, 1'b0);
        checkOutput("t1_strobe_t1", strobe_o, 0);
        tick();
        checkOutput("t1_strobe_t2", strobe_o, 1);
        checkOutput("t1_data", data_o, 8'h10);
        tick();
        checkOutput("t1_strobe_pulse", strobe_o, 0);
        for (int i = 0; i < 17; i++) tick();
        checkOutput("t1_busy_waiting", busy_o, 1);
        checkOutput("t1_data_held", data_o, 8'h10);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t1_idle_after_done", busy_o, 0);

        $display("[TB] fill FIFO with enable low");
        enable = 1'b0;
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b0);
        checkOutput("t2_ready_3", wr_ready, 1);
        applyStimulus(8'h44, 1'b1, 1'b0);
        checkOutput("t2_ready_full", wr_ready, 0);
        checkOutput("t2_no_start", busy_o, 0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitStrobe(20, seen);
            checkOutput($sformatf("t2_strobe_%0d", k), seen, 1);
            checkOutput($sformatf("t2_data_%0d", k), data_o, expData[k]);
            tick();
            applyStimulus(8'h00, 1'b0, 1'b1);
        end
        countStrobes(10, n);
        checkOutput("t2_dropped_no_strobe", n, 0);
        checkOutput("t2_idle", busy_o, 0);

        $display("[TB] rate_div gap");
        rate_div = 8'd3;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        checkOutput("t3_strobe_A5", strobe_o, 1);
        checkOutput("t3_data_A5", data_o, 8'hA5);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_o !== 8'hA5 || strobe_o !== 1'b0) stable = 1'b0;
        end
        checkOutput("t3_data_stable", stable, 1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        n = 0;
        for (int i = 1; i <= 3; i++) begin
            if (strobe_o) n++;
            tick();
        end
        checkOutput("t3_idle_at_d4", busy_o, 0);
        checkOutput("t3_early_strobes", n, 0);
        tick();
        checkOutput("t3_strobe_d5", strobe_o, 1);
        checkOutput("t3_data_5A", data_o, 8'h5A);

        $display("[TB] done ignored outside WAIT_DONE");
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t4_wr_d2_busy", busy_o, 1);
        tick();
        checkOutput("t4_wr_d3_busy", busy_o, 1);
        tick();
        checkOutput("t4_wr_d4_idle", busy_o, 0);
        rate_div = 8'd0;
        enable = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t4_idle_done_busy", busy_o, 0);
        applyStimulus(8'h77, 1'b1, 1'b0);
        enable = 1'b1;
        waitStrobe(10, seen);
        checkOutput("t4_strobe_77", seen, 1);
        checkOutput("t4_data_77", data_o, 8'h77);
        tick(); tick(); tick();
        checkOutput("t4_done_not_queued", busy_o, 1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        countStrobes(5, n);
        checkOutput("t4_no_extra_strobe", n, 0);

        $display("[TB] reset in WAIT_DONE");
        enable = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b0);
        applyStimulus(8'h03, 1'b1, 1'b0);
        enable = 1'b1;
        waitStrobe(10, seen);
        checkOutput("t5_strobe_01", seen, 1);
        enable = 1'b0;
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_data", data_o, 8'h00);
        checkOutput("t5_rst_busy", busy_o, 0);
        checkOutput("t5_rst_strobe", strobe_o, 0);
        tick();
        reset = 1'b0;
        enable = 1'b1;
        countStrobes(10, n);
        checkOutput("t5_fifo_empty", n, 0);
        checkOutput("t5_idle", busy_o, 0);

`ifdef DONE_TIMEOUT_EN
        $display("[TB] done timeout");
        enable = 1'b0;
        applyStimulus(8'h9C, 1'b1, 1'b0);
        applyStimulus(8'hC9, 1'b1, 1'b0);
        enable = 1'b1;
        waitStrobe(10, seen);
        checkOutput("t6_strobe_9C", seen, 1);
        // Counter is 0 on the first WAIT_DONE cycle and reaches 63 on the 64th; the
        // flag is visible one cycle later, 65 ticks after the strobe cycle.
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (timeout_o) begin
                n = i;
                break;
            end
        end
        checkOutput("t6_timeout_cycle", n, 65);
        checkOutput("t6_idle", busy_o, 0);
        tick();
        checkOutput("t6_next_strobe", strobe_o, 1);
        checkOutput("t6_next_data", data_o, 8'hC9);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t6_sticky", timeout_o, 1);
`else
        $display("[TB] no timeout without DONE_TIMEOUT_EN");
        applyStimulus(8'h9C, 1'b1, 1'b0);
        waitStrobe(10, seen);
        checkOutput("t6_strobe_9C", seen, 1);
        for (int i = 0; i < 80; i++) tick();
        checkOutput("t6_still_waiting", busy_o, 1);
        checkOutput("t6_timeout_zero", timeout_o, 0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("t6_idle", busy_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
